// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster geometry, counter sizing helper and flag payload
// used by vga_timing and by display.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam logic        VGA_SYNC_POL = 1'b0;

  localparam int unsigned COORD_W     = 32;
  localparam int unsigned MIN_CNT_W   = 10;

  // Counters hold at least 10 bits and can always represent the total itself.
  function automatic int unsigned cnt_width(input int unsigned total);
    int unsigned w;
    w = $clog2(total + 1);
    return (w < MIN_CNT_W) ? MIN_CNT_W : w;
  endfunction

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vnotactive;
    logic frame_start;
  } vga_flags_t;

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel-rate divider: one-CLK pix_ce strobe every CLK_DIV system clocks.
module pix_ce_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic pix_ce
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  // Strobe is registered from the next divider value so it tracks div exactly.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      div_q  <= '0;
      pix_ce <= (CLK_DIV == 1);
    end else begin
      div_q  <= div_nxt;
      pix_ce <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel divider, h/v counters, registered sync,
// blanking and per-frame strobe aligned with the coordinates.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter logic        SYNC_POL = VGA_SYNC_POL
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               vnotactive,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_ce,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = cnt_width(H_TOTAL);
  localparam int unsigned V_W     = cnt_width(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_VIS    = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] col_q, col_nxt;
  logic [V_W-1:0] row_q, row_nxt;
  vga_flags_t     flags_q, flags_nxt;
  logic           wrap_c;

  pix_ce_gen #(.CLK_DIV(CLK_DIV)) u_pix_ce_gen (
    .CLK    (CLK),
    .RST    (RST),
    .pix_ce (pix_ce)
  );

  // Next coordinates; flags decode from them so they land on the same edge.
  always_comb begin
    col_nxt = col_q;
    row_nxt = row_q;
    wrap_c  = 1'b0;
    if (pix_ce) begin
      if (col_q == H_LAST) begin
        col_nxt = '0;
        if (row_q == V_LAST) begin
          row_nxt = '0;
          wrap_c  = 1'b1;
        end else begin
          row_nxt = row_q + V_W'(1);
        end
      end else begin
        col_nxt = col_q + H_W'(1);
      end
    end

    flags_nxt.hsync       = ((col_nxt >= HS_START) && (col_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    flags_nxt.vsync       = ((row_nxt >= VS_START) && (row_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    flags_nxt.vnotactive  = (col_nxt >= H_VIS) || (row_nxt >= V_VIS);
    flags_nxt.frame_start = wrap_c;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      col_q                 <= '0;
      row_q                 <= '0;
      flags_q.hsync         <= ~SYNC_POL;
      flags_q.vsync         <= ~SYNC_POL;
      flags_q.vnotactive    <= 1'b0;
      flags_q.frame_start   <= 1'b0;
    end else begin
      col_q   <= col_nxt;
      row_q   <= row_nxt;
      flags_q <= flags_nxt;
    end
  end

  assign col         = COORD_W'(col_q);
  assign row         = COORD_W'(row_q);
  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign vnotactive  = flags_q.vnotactive;
  assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full 640x480 line timing on one instance,
// frame/wrap/reset behaviour on two reduced-geometry instances.
module tb_vga_timing;

  logic clk;
  logic rst0, rst1, rst2;

  logic [31:0] col0, row0, col1, row1, col2, row2;
  logic vna0, hs0, vs0, ce0, fs0;
  logic vna1, hs1, vs1, ce1, fs1;
  logic vna2, hs2, vs2, ce2, fs2;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing u_dut0 (
    .CLK(clk), .RST(rst0), .col(col0), .row(row0), .vnotactive(vna0),
    .hsync(hs0), .vsync(vs0), .pix_ce(ce0), .frame_start(fs0)
  );

  // 15x8 raster, divide by 3, active-high syncs
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(3), .SYNC_POL(1'b1)
  ) u_dut1 (
    .CLK(clk), .RST(rst1), .col(col1), .row(row1), .vnotactive(vna1),
    .hsync(hs1), .vsync(vs1), .pix_ce(ce1), .frame_start(fs1)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b0)
  ) u_dut2 (
    .CLK(clk), .RST(rst2), .col(col2), .row(row2), .vnotactive(vna2),
    .hsync(hs2), .vsync(vs2), .pix_ce(ce2), .frame_start(fs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fall_k, fall2_k, rise_k;
    int fs_a, fs_b, fs_cnt, vs_on, vs_off;
    logic prev_h, prev_v;

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (3) tick();
    check("rst_col",   col0, 0);
    check("rst_row",   row0, 0);
    check("rst_hsync", 32'(hs0), 1);
    check("rst_vsync", 32'(vs0), 1);
    check("rst_vna",   32'(vna0), 0);
    check("rst_fs",    32'(fs0), 0);
    check("rst_ce",    32'(ce0), 0);
    check("rst_ce_div1", 32'(ce2), 1);

    // Full-size line timing, CLK_DIV=2
    rst0 = 1'b1;
    fall_k = -1; fall2_k = -1; rise_k = -1; prev_h = 1'b1;
    for (int k = 1; k <= 3400; k++) begin
      tick();
      if (k <= 4) check("col_step", col0, 32'(k / 2));
      if (k == 1279) check("vna_639", 32'(vna0), 0);
      if (k == 1280) begin
        check("col_640", col0, 640);
        check("vna_640", 32'(vna0), 1);
      end
      if (prev_h && !hs0) begin
        if (fall_k < 0) begin
          fall_k = k;
          check("hs_fall_col", col0, 656);
        end else if (fall2_k < 0) begin
          fall2_k = k;
        end
      end
      if (!prev_h && hs0 && rise_k < 0) rise_k = k;
      prev_h = hs0;
    end
    check("hs_fall_k",  32'(fall_k), 1312);
    check("hs_width",   32'(rise_k - fall_k), 192);
    check("hs_period",  32'(fall2_k - fall_k), 1600);
    check("end_col",    col0, 100);
    check("end_row",    row0, 2);
    check("col_hi",     col0 >> 10, 0);
    check("fs_none",    32'(fs0), 0);

    // Mid-count reset
    rst0 = 1'b0;
    repeat (3) tick();
    check("mrst_col",   col0, 0);
    check("mrst_row",   row0, 0);
    check("mrst_hsync", 32'(hs0), 1);
    check("mrst_vsync", 32'(vs0), 1);
    check("mrst_vna",   32'(vna0), 0);
    check("mrst_fs",    32'(fs0), 0);

    // Reduced raster: frame strobe, vsync window, wrap
    rst1 = 1'b1;
    fs_a = -1; fs_b = -1; fs_cnt = 0; vs_on = -1; vs_off = -1; prev_v = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (fs1) begin
        fs_cnt++;
        if (fs_a < 0) fs_a = k;
        else if (fs_b < 0) fs_b = k;
      end
      if (!prev_v && vs1 && vs_on < 0) vs_on = k;
      if (prev_v && !vs1 && vs_off < 0) vs_off = k;
      prev_v = vs1;
      if (k == 29) begin
        check("d1_col9",  col1, 9);
        check("d1_hs_off", 32'(hs1), 0);
      end
      if (k == 30) check("d1_hs_on", 32'(hs1), 1);
      if (k == 359) begin
        check("wrap_pre_col", col1, 14);
        check("wrap_pre_row", row1, 7);
        check("wrap_pre_vna", 32'(vna1), 1);
        check("wrap_pre_fs",  32'(fs1), 0);
      end
      if (k == 360) begin
        check("wrap_col", col1, 0);
        check("wrap_row", row1, 0);
        check("wrap_vna", 32'(vna1), 0);
        check("wrap_fs",  32'(fs1), 1);
      end
      if (k == 361) check("wrap_fs_len", 32'(fs1), 0);
    end
    check("fs_count",  32'(fs_cnt), 2);
    check("fs_first",  32'(fs_a), 360);
    check("fs_period", 32'(fs_b - fs_a), 360);
    check("vs_on_k",   32'(vs_on), 225);
    check("vs_width",  32'(vs_off - vs_on), 90);

    // CLK_DIV=1: reset mid-frame, then per-cycle stepping
    rst2 = 1'b1;
    for (int k = 1; k <= 35; k++) tick();
    check("d2_col", col2, 5);
    check("d2_row", row2, 2);
    rst2 = 1'b0;
    tick();
    check("d2rst_col",   col2, 0);
    check("d2rst_row",   row2, 0);
    check("d2rst_hsync", 32'(hs2), 1);
    check("d2rst_vsync", 32'(vs2), 1);
    check("d2rst_vna",   32'(vna2), 0);
    check("d2rst_fs",    32'(fs2), 0);
    check("d2rst_ce",    32'(ce2), 1);
    rst2 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("d2_step", col2, 32'(k));
      check("d2_ce",   32'(ce2), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
